game_state_manager: RTL and testbench

GAME_STATE_MANAGER -- requirements
Module: game_state_manager

---
 rtl/game_pkg.sv | 29 ++
 rtl/frame_countdown.sv | 27 ++
 rtl/game_state_manager.sv | 131 +++++++++++++
 tb/tb_game_state_manager.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, tile codes and score helpers for the game state manager
package game_pkg;

  localparam int SCORE_W = 10;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    FREEZE = 3'd2,
    WON    = 3'd3,
    LOST   = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    BACKGROUND = 2'b00,
    FLOOR      = 2'b01,
    GIFT       = 2'b10,
    HOLE       = 2'b11
  } tile_t;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - frame-based countdown used for the post-life-loss motion freeze
module frame_countdown #(
  parameter logic [7:0] FRAMES = 8'd30
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic startOfFrame,
  output logic done
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= FRAMES;
    end else if (en && startOfFrame && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);

endmodule

// File: rtl/game_state_manager.sv
// rtl/game_state_manager.sv - game FSM: gift counting, lives, freeze and win/lose handling
// Optional score register is built only when GAME_SCORE_EN is defined.
module game_state_manager
  import game_pkg::*;
#(
  parameter logic [5:0]         INIT_GIFTS    = 6'd10,
  parameter logic [1:0]         INIT_LIVES    = 2'd3,
  parameter logic [7:0]         FREEZE_FRAMES = 8'd30,
  parameter logic [SCORE_W-1:0] GIFT_POINTS   = 10'd5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               WriteEn,
  input  logic               SingleHitPulse,
  input  logic               endgame,
  input  logic               victory,
  input  logic               lifeLost,
  output logic [5:0]         numOfGifts,
  output logic               showHole,
  output logic               motionEn,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         gameState
);

  game_state_t state, next_state;

  logic       start_prev, start_rise, in_play, reload;
  logic       gift_flag, flag_now, flag_d;
  logic       win, loss, gift_try, gift_take;
  logic       freeze_load, freeze_done;
  logic [5:0] gifts_d;
  logic [1:0] lives_d;
  logic [15:0] hit_count;

  assign start_rise  = startKey & ~start_prev;
  assign in_play     = (state == PLAY);
  assign reload      = start_rise & ((state == IDLE) | (state == WON) | (state == LOST));
  // startOfFrame opens a new frame in the same cycle, so a coincident WriteEn is the frame's first
  assign flag_now    = gift_flag & ~startOfFrame;
  assign win         = in_play & endgame & victory & showHole;
  assign loss        = in_play & ~win & (lifeLost | (endgame & ~showHole));
  assign gift_try    = in_play & ~win & ~loss & WriteEn & ~flag_now;
  assign gift_take   = gift_try & (numOfGifts != 6'd0);
  assign freeze_load = loss & (lives != 2'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, WON, LOST: if (start_rise) next_state = PLAY;
      PLAY: begin
        if (win)       next_state = WON;
        else if (loss) next_state = (lives == 2'd1) ? LOST : FREEZE;
      end
      FREEZE:  if (freeze_done) next_state = PLAY;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gifts_d = numOfGifts;
    lives_d = lives;
    flag_d  = flag_now | gift_try;
    if (reload) begin
      gifts_d = INIT_GIFTS;
      lives_d = INIT_LIVES;
      flag_d  = 1'b0;
    end else begin
      if (gift_take) gifts_d = numOfGifts - 6'd1;
      if (loss)      lives_d = lives - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      numOfGifts <= INIT_GIFTS;
      lives      <= INIT_LIVES;
      showHole   <= 1'b0;
      motionEn   <= 1'b0;
      gift_flag  <= 1'b0;
      start_prev <= 1'b1;
    end else begin
      numOfGifts <= gifts_d;
      lives      <= lives_d;
      showHole   <= (gifts_d == 6'd0);
      motionEn   <= (next_state == PLAY);
      gift_flag  <= flag_d;
      start_prev <= startKey;
    end
  end

  assign gameState = state;

`ifdef GAME_SCORE_EN
  logic [SCORE_W-1:0] score_q;

  always_ff @(posedge clk) begin
    if (reset || reload) score_q <= '0;
    else if (gift_take)  score_q <= sat_add(score_q, GIFT_POINTS);
  end

  assign score = score_q;
`else
  assign score = GIFT_POINTS & {SCORE_W{1'b0}};
`endif

  // Debug-only collision tally; not exported
  always_ff @(posedge clk) begin
    if (reset)               hit_count <= 16'd0;
    else if (SingleHitPulse) hit_count <= hit_count + 16'd1;
  end

  frame_countdown #(
    .FRAMES(FREEZE_FRAMES)
  ) u_freeze (
    .clk         (clk),
    .reset       (reset),
    .load        (freeze_load),
    .en          (state == FREEZE),
    .startOfFrame(startOfFrame),
    .done        (freeze_done)
  );

endmodule

// File: tb/tb_game_state_manager.sv
// tb/tb_game_state_manager.sv - directed and randomized checks against a behavioural game model
module tb_game_state_manager;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1, startOfFrame = 1'b0, startKey = 1'b0, WriteEn = 1'b0;
  logic SingleHitPulse = 1'b0, endgame = 1'b0, victory = 1'b0, lifeLost = 1'b0;
  logic [5:0] numOfGifts;
  logic       showHole, motionEn;
  logic [1:0] lives;
  logic [9:0] score;
  logic [2:0] gameState;

  int errors = 0;
  int checks = 0;

  game_state_t m_state;
  int m_gifts, m_lives, m_score, m_frames;
  bit m_flag, m_prev_sk;

  game_state_manager dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .startKey      (startKey),
    .WriteEn       (WriteEn),
    .SingleHitPulse(SingleHitPulse),
    .endgame       (endgame),
    .victory       (victory),
    .lifeLost      (lifeLost),
    .numOfGifts    (numOfGifts),
    .showHole      (showHole),
    .motionEn      (motionEn),
    .lives         (lives),
    .score         (score),
    .gameState     (gameState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_score(input int s);
`ifdef GAME_SCORE_EN
    return s;
`else
    return 0;
`endif
  endfunction

  // One clock of the game rules, applied to the inputs present before the edge
  task automatic model_step();
    bit rise, flag_now, hole;
    if (reset) begin
      m_state = IDLE; m_gifts = 10; m_lives = 3; m_score = 0;
      m_frames = 0; m_flag = 0; m_prev_sk = 1;
      return;
    end
    rise      = startKey && !m_prev_sk;
    m_prev_sk = startKey;
    flag_now  = m_flag && !startOfFrame;
    hole      = (m_gifts == 0);
    m_flag    = flag_now;
    case (m_state)
      PLAY: begin
        if (endgame && victory && hole) begin
          m_state = WON;
        end else if (lifeLost || (endgame && !hole)) begin
          m_lives = m_lives - 1;
          m_state = (m_lives == 0) ? LOST : FREEZE;
          m_frames = 30;
        end else if (WriteEn && !flag_now) begin
          m_flag = 1;
          if (m_gifts > 0) begin
            m_gifts = m_gifts - 1;
            m_score = (m_score + 5 > 1023) ? 1023 : m_score + 5;
          end
        end
      end
      FREEZE: begin
        if (m_frames == 0)     m_state = PLAY;
        else if (startOfFrame) m_frames = m_frames - 1;
      end
      default: begin
        if (rise) begin
          m_state = PLAY; m_gifts = 10; m_lives = 3; m_score = 0; m_flag = 0;
        end
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_state", 32'(gameState), 32'(m_state));
    check("model_gifts", 32'(numOfGifts), m_gifts);
    check("model_lives", 32'(lives), m_lives);
    check("model_score", 32'(score), exp_score(m_score));
    check("model_motion", 32'(motionEn), 32'(m_state == PLAY));
    check("model_hole", 32'(showHole), 32'(m_gifts == 0));
  endtask

  task automatic frame_with_gift(input int n);
    startOfFrame = 1; tick(); startOfFrame = 0;
    WriteEn = 1; repeat (n) tick(); WriteEn = 0;
    tick();
  endtask

  task automatic press_start();
    startKey = 0; tick();
    startKey = 1; tick();
    startKey = 0;
  endtask

  task automatic sof_gap();
    startOfFrame = 1; tick(); startOfFrame = 0;
    repeat (3) tick();
  endtask

  task automatic wait_freeze();
    int n = 0;
    while (gameState == 3'(FREEZE) && n < 40) begin
      sof_gap();
      n++;
    end
    check("freeze_sof_count", n, 30);
    check("freeze_exit_play", 32'(gameState), 32'(PLAY));
  endtask

  initial begin
    reset = 1; startKey = 1;
    repeat (2) tick();
    check("rst_gifts", 32'(numOfGifts), 10);
    check("rst_lives", 32'(lives), 3);
    check("rst_motion", 32'(motionEn), 0);
    check("rst_hole", 32'(showHole), 0);
    check("rst_score", 32'(score), 0);
    reset = 0;
    repeat (2) tick();
    check("held_key_no_start", 32'(gameState), 32'(IDLE));

    startKey = 0; tick(); startKey = 1; tick(); startKey = 0;
    check("start_state", 32'(gameState), 32'(PLAY));
    check("start_gifts", 32'(numOfGifts), 10);
    check("start_lives", 32'(lives), 3);
    check("start_motion", 32'(motionEn), 1);

    frame_with_gift(50);
    check("frame1_gifts", 32'(numOfGifts), 9);
    check("frame1_score", 32'(score), exp_score(5));
    frame_with_gift(50);
    check("frame2_gifts", 32'(numOfGifts), 8);
    check("frame2_score", 32'(score), exp_score(10));

    repeat (8) frame_with_gift(5);
    check("all_gifts_zero", 32'(numOfGifts), 0);
    check("all_gifts_hole", 32'(showHole), 1);
    frame_with_gift(5);
    check("gift_floor", 32'(numOfGifts), 0);
    endgame = 1; victory = 1; tick(); endgame = 0; victory = 0;
    check("win_state", 32'(gameState), 32'(WON));
    WriteEn = 1; tick(); WriteEn = 0;
    check("won_ignores_gift", 32'(numOfGifts), 0);

    press_start();
    check("restart_state", 32'(gameState), 32'(PLAY));
    check("restart_gifts", 32'(numOfGifts), 10);
    check("restart_score", 32'(score), 0);

    lifeLost = 1; tick(); lifeLost = 0;
    check("loss1_state", 32'(gameState), 32'(FREEZE));
    check("loss1_lives", 32'(lives), 2);
    check("loss1_motion", 32'(motionEn), 0);
    wait_freeze();
    lifeLost = 1; tick(); lifeLost = 0;
    check("loss2_lives", 32'(lives), 1);
    wait_freeze();
    lifeLost = 1; tick(); lifeLost = 0;
    check("loss3_state", 32'(gameState), 32'(LOST));
    check("loss3_lives", 32'(lives), 0);

    press_start();
    startOfFrame = 1; WriteEn = 1; endgame = 1; victory = 1; tick();
    startOfFrame = 0; WriteEn = 0; endgame = 0; victory = 0;
    check("nohole_end_is_loss", 32'(gameState), 32'(FREEZE));
    check("loss_beats_gift", 32'(numOfGifts), 10);
    wait_freeze();
    startOfFrame = 1; WriteEn = 1; tick(); startOfFrame = 0;
    repeat (10) tick(); WriteEn = 0; tick();
    check("sof_and_first_gift", 32'(numOfGifts), 9);
    repeat (9) frame_with_gift(3);
    startOfFrame = 1; WriteEn = 1; endgame = 1; victory = 1; tick();
    startOfFrame = 0; WriteEn = 0; endgame = 0; victory = 0;
    check("win_beats_gift", 32'(gameState), 32'(WON));

    press_start();
    lifeLost = 1; tick(); lifeLost = 0;
    sof_gap(); sof_gap();
    reset = 1; tick(); reset = 0;
    check("reset_in_freeze", 32'(gameState), 32'(IDLE));
    check("reset_in_freeze_lives", 32'(lives), 3);

    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      startOfFrame   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) startKey = ~startKey;
      WriteEn        = ($urandom_range(0, 2) == 0);
      endgame        = (m_gifts == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      victory        = $urandom_range(0, 1);
      lifeLost       = ($urandom_range(0, 149) == 0);
      SingleHitPulse = $urandom_range(0, 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
